// File: rtl/seq_divider_pkg.sv
// Shared package for the sequential divider: FSM state encoding and default operand width.
package seq_divider_pkg;

  localparam int DEFAULT_NUM_SIZE = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring division iteration: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and restore when the difference goes negative.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_rem,
  input  logic [W-1:0] i_quo,
  input  logic [W-1:0] i_dvs,
  output logic [W-1:0] o_rem,
  output logic [W-1:0] o_quo
);

  logic [W:0] w_shift;
  logic [W:0] w_diff;

  // Bit W of the difference is the borrow: set means the divisor did not fit.
  always_comb begin
    w_shift = {i_rem, i_quo[W-1]};
    w_diff  = w_shift - {1'b0, i_dvs};
    if (!w_diff[W]) begin
      o_rem = w_diff[W-1:0];
      o_quo = {i_quo[W-2:0], 1'b1};
    end else begin
      o_rem = w_shift[W-1:0];
      o_quo = {i_quo[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider with valid/ready handshakes on both sides.
// Define SEQ_DIVIDER_SIGNED_EN to enable two's-complement operation via is_signed.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int NUM_SIZE = DEFAULT_NUM_SIZE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_SIZE-1:0] dIn0,
  input  logic [NUM_SIZE-1:0] dIn1,
  input  logic                is_signed,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_SIZE-1:0] quotient,
  output logic [NUM_SIZE-1:0] remainder,
  output logic                div_by_zero,
  output logic                overflow
);

  localparam int CNT_W = (NUM_SIZE > 1) ? $clog2(NUM_SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(NUM_SIZE - 1);

  div_state_e          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [NUM_SIZE-1:0] r_rem;
  logic [NUM_SIZE-1:0] r_quo;
  logic [NUM_SIZE-1:0] r_dvs;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [NUM_SIZE-1:0] r_quotient;
  logic [NUM_SIZE-1:0] r_remainder;
  logic                r_div_by_zero;
  logic                r_overflow;

  logic [NUM_SIZE-1:0] w_a_mag;
  logic [NUM_SIZE-1:0] w_b_mag;
  logic                w_ovf_case;
  logic [NUM_SIZE-1:0] w_step_rem;
  logic [NUM_SIZE-1:0] w_step_quo;
  logic [NUM_SIZE-1:0] w_quo_fix;
  logic [NUM_SIZE-1:0] w_rem_fix;

`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam logic [NUM_SIZE-1:0] MIN_NEG = {1'b1, {(NUM_SIZE-1){1'b0}}};

  logic r_neg_q;
  logic r_neg_r;
  logic w_a_neg;
  logic w_b_neg;

  assign w_a_neg    = is_signed & dIn0[NUM_SIZE-1];
  assign w_b_neg    = is_signed & dIn1[NUM_SIZE-1];
  assign w_a_mag    = w_a_neg ? -dIn0 : dIn0;
  assign w_b_mag    = w_b_neg ? -dIn1 : dIn1;
  assign w_ovf_case = is_signed && (dIn0 == MIN_NEG) && (dIn1 == '1);
  // Quotient sign from the operand signs; remainder sign follows the dividend.
  assign w_quo_fix  = r_neg_q ? -w_step_quo : w_step_quo;
  assign w_rem_fix  = r_neg_r ? -w_step_rem : w_step_rem;
`else
  logic w_unused_sgn;

  assign w_unused_sgn = is_signed;
  assign w_a_mag      = dIn0;
  assign w_b_mag      = dIn1;
  assign w_ovf_case   = 1'b0;
  assign w_quo_fix    = w_step_quo;
  assign w_rem_fix    = w_step_rem;
`endif

  div_step #(.W(NUM_SIZE)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dvs (r_dvs),
    .o_rem (w_step_rem),
    .o_quo (w_step_quo)
  );

  // Handshake FSM, iteration counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_dvs         <= '0;
      r_in_ready    <= 1'b1;
      r_out_valid   <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
      r_overflow    <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_rem      <= '0;
            r_quo      <= w_a_mag;
            r_dvs      <= w_b_mag;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            r_neg_q    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg;
`endif
            if (dIn1 == '0) begin
              r_state       <= DONE;
              r_out_valid   <= 1'b1;
              r_quotient    <= '1;
              r_remainder   <= dIn0;
              r_div_by_zero <= 1'b1;
              r_overflow    <= 1'b0;
            end else if (w_ovf_case) begin
              r_state       <= DONE;
              r_out_valid   <= 1'b1;
              r_quotient    <= dIn0;
              r_remainder   <= '0;
              r_div_by_zero <= 1'b0;
              r_overflow    <= 1'b1;
            end else begin
              r_state <= BUSY;
            end
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        BUSY: begin
          r_rem <= w_step_rem;
          r_quo <= w_step_quo;
          // The final iteration writes the sign-corrected result directly.
          if (r_cnt == LAST_ITER) begin
            r_state       <= DONE;
            r_out_valid   <= 1'b1;
            r_quotient    <= w_quo_fix;
            r_remainder   <= w_rem_fix;
            r_div_by_zero <= 1'b0;
            r_overflow    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end else begin
            r_out_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cnt       <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;
  assign overflow    = r_overflow;

endmodule
